// File: rtl/level_sequencer_if.sv
// ============================================================================
// Module      : level_sequencer_if
// Description : Bundles the frame/level control inputs and the per-level
//               difficulty setting outputs of the level sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface level_sequencer_if;
    logic       startOfFrame;
    logic       level_up;
    logic       level_restart;
    logic [3:0] level;
    logic       level_changing;
    logic       game_won;
    logic [1:0] trees_to_add;
    logic [2:0] tree_speed;
    logic [1:0] bird_speed;
    logic       number_of_birds;
    logic [3:0] bird_life;

    // Score/collision side: raises events, consumes difficulty settings.
    modport master (
        output startOfFrame, level_up, level_restart,
        input  level, level_changing, game_won, trees_to_add,
               tree_speed, bird_speed, number_of_birds, bird_life
    );

    // Sequencer side.
    modport slave (
        input  startOfFrame, level_up, level_restart,
        output level, level_changing, game_won, trees_to_add,
               tree_speed, bird_speed, number_of_birds, bird_life
    );
endinterface

`default_nettype wire

// File: rtl/level_sequencer.sv
// ============================================================================
// Module      : level_sequencer
// Description : Parametrised game-level controller. Tracks the current level,
//               decodes difficulty knobs from it, holds a frame-counted freeze
//               window between levels and reports a won game or wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_sequencer #(
    parameter int NUM_LEVELS        = 8,
    parameter int TRANSITION_FRAMES = 60,
    parameter int WRAP_AT_END       = 0,
    parameter int LIFE_BASE         = 3
) (
    input  wire logic          clk,
    input  wire logic          resetN,
    level_sequencer_if.slave   bus
);

    localparam int LVL_W = $clog2(NUM_LEVELS);
    // A zero-frame build never enters TRANS; keep the counter one bit wide.
    localparam int CNT_W = (TRANSITION_FRAMES > 0) ? $clog2(TRANSITION_FRAMES + 1) : 1;

    localparam logic [LVL_W-1:0] c_LAST_LVL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] c_TF_CNT   = CNT_W'(TRANSITION_FRAMES);
    localparam logic [4:0]       c_LIFE     = 5'(LIFE_BASE);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_TRANS = 2'b01,
        ST_WON   = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LVL_W-1:0] r_lvl;
    logic [LVL_W-1:0] w_lvl_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [4:0]       w_lvl_ext;
    logic [4:0]       w_half;
    logic [4:0]       w_life_sum;

    // State, level and frame counter registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_PLAY;
            r_lvl   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lvl   <= w_lvl_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: restart beats level_up, level_up beats a frame tick.
    always_comb begin
        w_state_nxt = r_state;
        w_lvl_nxt   = r_lvl;
        w_cnt_nxt   = r_cnt;
        if (bus.level_restart) begin
            w_state_nxt = ST_PLAY;
            w_lvl_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (bus.level_up) begin
                        if ((r_lvl != c_LAST_LVL) || (WRAP_AT_END != 0)) begin
                            // Next level, or wrap back to the first one.
                            w_lvl_nxt = (r_lvl != c_LAST_LVL) ? r_lvl + 1'b1 : '0;
                            if (TRANSITION_FRAMES > 0) begin
                                w_state_nxt = ST_TRANS;
                                w_cnt_nxt   = c_TF_CNT;
                            end
                        end else begin
                            w_state_nxt = ST_WON;
                        end
                    end
                end
                ST_TRANS: begin
                    // level_up is dropped here; only frame ticks matter.
                    if (bus.startOfFrame) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_PLAY;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                end
                ST_WON: begin
                    // Terminal until restart or reset.
                    w_state_nxt = ST_WON;
                end
                default: begin
                    w_state_nxt = ST_PLAY;
                    w_lvl_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Difficulty knobs decoded from the registered level.
    always_comb begin
        w_lvl_ext  = 5'(r_lvl);
        w_half     = (w_lvl_ext + 5'd1) >> 1;
        w_life_sum = c_LIFE + (w_lvl_ext >> 1);

        bus.level           = w_lvl_ext[3:0];
        bus.level_changing  = (r_state == ST_TRANS);
        bus.game_won        = (r_state == ST_WON);
        bus.tree_speed      = (w_lvl_ext > 5'd7) ? 3'd7 : w_lvl_ext[2:0];
        bus.bird_speed      = (w_half > 5'd3) ? 2'd3 : w_half[1:0];
        bus.number_of_birds = (w_lvl_ext >= 5'd2);
        // The final level gets no extra trees even when odd.
        bus.trees_to_add    = ((w_lvl_ext < 5'd2) ||
                               (w_lvl_ext[0] && (r_lvl != c_LAST_LVL))) ? 2'd2 : 2'd0;
        bus.bird_life       = (w_life_sum > 5'd15) ? 4'd15 : w_life_sum[3:0];
    end

endmodule

`default_nettype wire
